// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared types and helpers for the ROM image write path.
//   ROM_AW      : default ioctl byte-address width
//   rom_entry_t : one buffered word (byte address + byte-swapped data)
//   bswap16     : swaps the two bytes of a 16-bit word
//   issue_state_t : request/ack issue FSM states
package rom_loader_pkg;

  localparam int ROM_AW = 25;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [15:0]       data;
  } rom_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } issue_state_t;

  function automatic logic [15:0] bswap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Show-ahead synchronous FIFO with modulo-DEPTH pointers.
//   clk_sys, reset_n : clock, async active-low reset
//   flush            : synchronous clear; a push in the same cycle is kept
//   push / wr_data   : write request (ignored when full, unless flushing)
//   pop              : read request (ignored when empty or flushing)
//   rd_data          : current head entry (valid when !empty)
//   count/full/empty : occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A flush frees every slot, so a simultaneous push always lands at slot 0.
  assign do_push = push && (flush || !full);
  assign do_pop  = pop && !empty && !flush;
  assign wr_idx  = flush ? '0 : wr_ptr;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_idx + 1'b1 : wr_idx;
      if (flush)
        rd_ptr <= '0;
      else if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (flush)
        count <= do_push ? CW'(1) : '0;
      else if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push)
      mem[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader
//   Write-side front end between the hps_io ioctl download port and the
//   DDR3 ROM store. Buffers ioctl words, byte-swaps them and hands them to
//   ddram one at a time over a toggle request/ack handshake.
//
//   clk_sys, reset_n          : clock, async active-low reset
//   ioctl_download            : download active level
//   ioctl_wr/addr/data        : word strobe, even byte address, file-order data
//   ioctl_wait                : registered back-pressure to hps_io
//   wraddr, din               : address / swapped data presented to ddram
//   we_req, we_ack            : toggle handshake, pending while they differ
//   rom_words                 : highest written word index + 1
//   load_done                 : one-cycle pulse once a finished load is committed
//   overflow                  : sticky, a word arrived while the FIFO was full
//
//   Issue FSM
//   state   | meaning
//   --------+---------------------------------------------------
//   ST_IDLE | no request outstanding, we_req == we_ack
//   ST_BUSY | request issued, waiting for we_ack to match we_req
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ROM_AW
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [15:0]   ioctl_data,
  output logic          ioctl_wait,
  output logic [AW-1:0] wraddr,
  output logic [15:0]   din,
  output logic          we_req,
  input  logic          we_ack,
  output logic [AW-2:0] rom_words,
  output logic          load_done,
  output logic          overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(rom_entry_t);

  issue_state_t   state_q, state_d;
  logic           dl_old;
  logic           dl_rise;
  logic           dl_fall;
  logic           wr_ok;
  logic           push_ok;
  logic           issue;
  logic           req_idle;
  logic           done_armed;
  logic           done_cond;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  cnt_nx;
  logic [EW-1:0]  fifo_rd;
  rom_entry_t     head;
  rom_entry_t     wr_entry;
  logic [AW-2:0]  word_nx;

  assign dl_rise   = ioctl_download && !dl_old;
  assign dl_fall   = !ioctl_download && dl_old;
  assign wr_ok     = ioctl_wr && ioctl_download;
  // The flush on a rising edge empties the FIFO first, so that write is kept.
  assign push_ok   = wr_ok && (dl_rise || !fifo_full);
  assign req_idle  = (we_req == we_ack);
  assign done_cond = !ioctl_download && fifo_empty && req_idle;
  assign word_nx   = ioctl_addr[AW-1:1] + 1'b1;
  assign wr_entry  = '{addr: ROM_AW'(ioctl_addr), data: bswap16(ioctl_data)};
  assign head      = fifo_rd;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .flush   (dl_rise),
    .push    (push_ok),
    .wr_data (wr_entry),
    .pop     (issue),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Occupancy after this edge, used for the registered wait flag.
  always_comb begin
    cnt_nx = dl_rise ? '0 : fifo_count;
    if (push_ok)
      cnt_nx = cnt_nx + 1'b1;
    if (issue)
      cnt_nx = cnt_nx - 1'b1;
  end

  // Words sitting in the FIFO on a rising edge are being discarded, so
  // nothing is issued on that edge.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_idle && !fifo_empty && !dl_rise) begin
          issue   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (req_idle) begin
          if (!fifo_empty && !dl_rise)
            issue = 1'b1;
          else
            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dl_old     <= 1'b0;
      we_req     <= 1'b0;
      wraddr     <= '0;
      din        <= '0;
      rom_words  <= '0;
      overflow   <= 1'b0;
      ioctl_wait <= 1'b0;
      load_done  <= 1'b0;
      done_armed <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_old  <= ioctl_download;

      if (issue) begin
        wraddr <= head.addr[AW-1:0];
        din    <= head.data;
        we_req <= ~we_req;
      end

      if (dl_rise)
        rom_words <= push_ok ? word_nx : '0;
      else if (push_ok && (word_nx > rom_words))
        rom_words <= word_nx;

      if (dl_rise)
        overflow <= 1'b0;
      else if (wr_ok && fifo_full)
        overflow <= 1'b1;

      // Rising at DEPTH-1 leaves one slot for a write already in flight.
      ioctl_wait <= ioctl_download && (cnt_nx >= CW'(DEPTH - 1));

      load_done <= 1'b0;
      if (dl_rise)
        done_armed <= 1'b0;
      else if (dl_fall)
        done_armed <= 1'b1;
      else if (done_armed && done_cond) begin
        load_done  <= 1'b1;
        done_armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
module tb_rom_loader;
  localparam int AW    = 25;
  localparam int DEPTH = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [15:0]   ioctl_data = '0;
  logic          ioctl_wait;
  logic [AW-1:0] wraddr;
  logic [15:0]   din;
  logic          we_req;
  logic          we_ack;
  logic [AW-2:0] rom_words;
  logic          load_done;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  rom_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .wraddr         (wraddr),
    .din            (din),
    .we_req         (we_req),
    .we_ack         (we_ack),
    .rom_words      (rom_words),
    .load_done      (load_done),
    .overflow       (overflow)
  );

  function automatic logic [15:0] sw(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  // ddram model: logs each new request, checks it is held, acks after ack_delay samples.
  logic [AW+15:0] req_log[$];
  logic [AW+15:0] cur_req;
  bit ack_freeze = 1'b0;
  bit rnd_ack    = 1'b0;
  int ack_delay  = 1;
  int ack_cnt    = 0;

  initial begin
    we_ack = 1'b0;
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) begin
        we_ack  = 1'b0;
        ack_cnt = 0;
      end else begin
        #2;
        if (reset_n && we_req !== we_ack) begin
          if (ack_cnt == 0) begin
            cur_req = {wraddr, din};
            req_log.push_back(cur_req);
            if (rnd_ack) ack_delay = $urandom_range(1, 4);
          end else begin
            n_tests++;
            if ({wraddr, din} !== cur_req) begin
              n_fail++;
              $display("FAIL hold: wraddr/din=%h while pending, expected %h", {wraddr, din}, cur_req);
            end
          end
          ack_cnt++;
          if (!ack_freeze && ack_cnt >= ack_delay) begin
            we_ack  = we_req;
            ack_cnt = 0;
          end
        end
      end
    end
  end

  int done_cnt = 0;
  always @(negedge clk_sys) if (load_done === 1'b1) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic new_download();
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wait_log(input int n, input int limit, input string nm);
    int k = 0;
    while (req_log.size() < n && k < limit) begin tick(); k++; end
    if (req_log.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout, %0d requests seen, wanted %0d", nm, req_log.size(), n);
    end
  endtask

  task automatic wait_idle(input int limit, input string nm);
    int k = 0;
    while (we_req !== we_ack && k < limit) begin tick(); k++; end
    if (we_req !== we_ack) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout waiting for ack, we_req=%b we_ack=%b", nm, we_req, we_ack);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    n_tests++;
    if ({ioctl_wait, we_req, load_done, overflow} !== 4'b0 || wraddr !== '0 || din !== '0 || rom_words !== '0) begin
      n_fail++;
      $display("FAIL reset: wait=%b req=%b done=%b ovf=%b wraddr=%h din=%h words=%0d, expected all 0",
               ioctl_wait, we_req, load_done, overflow, wraddr, din, rom_words);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic r0;
    new_download();
    ack_freeze = 1'b0; ack_delay = 3; req_log.delete();
    r0 = we_req;
    wr_word('0, 16'h1234);
    n_tests++;
    if (we_req !== r0) begin n_fail++; $display("FAIL single_early: we_req=%b expected %b", we_req, r0); end
    tick();
    n_tests++;
    if (wraddr !== '0 || din !== 16'h3412 || we_req !== ~r0) begin
      n_fail++;
      $display("FAIL single_issue: wraddr=%h din=%h we_req=%b, expected 0 3412 %b", wraddr, din, we_req, ~r0);
    end
    tick();
    n_tests++;
    if (we_req !== ~r0 || we_ack === we_req) begin
      n_fail++; $display("FAIL single_pending: we_req=%b we_ack=%b, expected pending", we_req, we_ack);
    end
    tick(6);
    n_tests++;
    if (req_log.size() != 1 || we_ack !== we_req || rom_words !== 1) begin
      n_fail++;
      $display("FAIL single_done: requests=%0d idle=%b words=%0d, expected 1 1 1", req_log.size(), we_ack === we_req, rom_words);
    end
  endtask

  task automatic test_wait();
    logic [15:0] d[5];
    new_download();
    ack_freeze = 1'b1; req_log.delete();
    for (int i = 0; i < 5; i++) begin
      d[i] = 16'($urandom);
      wr_word(AW'(2 * i), d[i]);
      if (i == 2) begin
        n_tests++;
        if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL wait_low: ioctl_wait=%b expected 0", ioctl_wait); end
      end
      if (i == 3) begin
        n_tests++;
        if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL wait_high: ioctl_wait=%b expected 1", ioctl_wait); end
      end
    end
    tick(20);
    n_tests++;
    if (overflow !== 1'b0 || req_log.size() != 1) begin
      n_fail++; $display("FAIL wait_hold: overflow=%b requests=%0d, expected 0 1", overflow, req_log.size());
    end
    ack_freeze = 1'b0; ack_delay = 1;
    wait_log(5, 100, "wait_drain");
    wait_idle(20, "wait_idle");
    for (int i = 0; i < 5 && i < req_log.size(); i++) begin
      n_tests++;
      if (req_log[i] !== {AW'(2 * i), sw(d[i])}) begin
        n_fail++; $display("FAIL wait_order[%0d]: got %h expected %h", i, req_log[i], {AW'(2 * i), sw(d[i])});
      end
    end
    n_tests++;
    if (rom_words !== 5 || overflow !== 1'b0 || ioctl_wait !== 1'b0) begin
      n_fail++; $display("FAIL wait_final: words=%0d ovf=%b wait=%b, expected 5 0 0", rom_words, overflow, ioctl_wait);
    end
  endtask

  task automatic test_end_of_load();
    int d0, t_match, t_done, seen;
    new_download();
    ack_freeze = 1'b1; req_log.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) wr_word(AW'(16 + 2 * i), 16'($urandom));
    tick();
    ioctl_download = 1'b0;
    tick();
    n_tests++;
    if (load_done !== 1'b0 || req_log.size() != 1) begin
      n_fail++; $display("FAIL eol_early: done=%b requests=%0d, expected 0 1", load_done, req_log.size());
    end
    ack_freeze = 1'b0; ack_delay = 2;
    t_match = -1; t_done = -1; seen = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (t_match < 0 && req_log.size() == 3 && we_req === we_ack) t_match = t;
      if (load_done === 1'b1) begin
        if (t_done < 0) t_done = t;
        seen++;
      end
    end
    n_tests++;
    if (t_match < 0 || t_done != t_match || seen != 1) begin
      n_fail++; $display("FAIL eol_pulse: done at %0d match at %0d pulses=%0d, expected equal and 1", t_done, t_match, seen);
    end
    n_tests++;
    if (done_cnt - d0 != 1 || rom_words !== 11) begin
      n_fail++; $display("FAIL eol_final: pulses=%0d words=%0d, expected 1 11", done_cnt - d0, rom_words);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d[6];
    new_download();
    ack_freeze = 1'b1; req_log.delete();
    for (int i = 0; i < 6; i++) begin
      d[i] = 16'($urandom);
      wr_word(AW'(2 * i), d[i]);
    end
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: overflow=%b expected 1", overflow); end
    ack_freeze = 1'b0; ack_delay = 1;
    wait_log(5, 100, "ovf_drain");
    wait_idle(20, "ovf_idle");
    tick(10);
    n_tests++;
    if (req_log.size() != 5 || req_log[req_log.size() - 1] !== {AW'(8), sw(d[4])} || rom_words !== 5) begin
      n_fail++; $display("FAIL ovf_drop: requests=%0d words=%0d, expected 5 5 with last addr 8", req_log.size(), rom_words);
    end
    new_download();
    n_tests++;
    if (overflow !== 1'b0 || rom_words !== 0) begin
      n_fail++; $display("FAIL ovf_clear: overflow=%b words=%0d, expected 0 0", overflow, rom_words);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    logic [15:0] dd;
    new_download();
    ack_freeze = 1'b1; req_log.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) wr_word(AW'(2 * i), 16'($urandom));
    #3 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({ioctl_wait, we_req, load_done, overflow} !== 4'b0 || wraddr !== '0 || din !== '0 || rom_words !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: wait=%b req=%b done=%b ovf=%b wraddr=%h din=%h words=%0d, expected all 0",
               ioctl_wait, we_req, load_done, overflow, wraddr, din, rom_words);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    req_log.delete(); ack_freeze = 1'b0; ack_delay = 2;
    tick();
    dd = 16'($urandom);
    wr_word(AW'(32), dd);
    wait_log(1, 20, "rst_issue");
    wait_idle(20, "rst_idle");
    tick(3);
    n_tests++;
    if (req_log.size() != 1 || req_log[0] !== {AW'(32), sw(dd)} || rom_words !== 17) begin
      n_fail++; $display("FAIL rst_after: requests=%0d words=%0d, expected 1 17 with addr 32", req_log.size(), rom_words);
    end
    n_tests++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL rst_nodone: pulses=%0d expected 0", done_cnt - d0); end
  endtask

  task automatic test_restart();
    int d0;
    logic [15:0] d[3];
    logic [15:0] e[2];
    new_download();
    ack_freeze = 1'b1; req_log.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      d[i] = 16'($urandom);
      wr_word(AW'(2 * i), d[i]);
    end
    ioctl_download = 1'b0; tick();
    ioctl_download = 1'b1; tick();
    n_tests++;
    if (we_req === we_ack || req_log.size() != 1) begin
      n_fail++; $display("FAIL rs_pending: pending=%b requests=%0d, expected 1 1", we_req !== we_ack, req_log.size());
    end
    ack_freeze = 1'b0; ack_delay = 2;
    wait_idle(20, "rs_idle");
    tick(3);
    n_tests++;
    if (req_log.size() != 1) begin n_fail++; $display("FAIL rs_flush: requests=%0d expected 1", req_log.size()); end
    for (int i = 0; i < 2; i++) begin
      e[i] = 16'($urandom);
      wr_word(AW'(64 + 2 * i), e[i]);
    end
    wait_log(3, 40, "rs_new");
    wait_idle(20, "rs_idle2");
    tick(3);
    n_tests++;
    if (req_log.size() != 3 || req_log[0] !== {AW'(0), sw(d[0])} ||
        req_log[1] !== {AW'(64), sw(e[0])} || req_log[2] !== {AW'(66), sw(e[1])}) begin
      n_fail++; $display("FAIL rs_order: requests=%0d first=%h, expected 3 with old head then new words", req_log.size(), req_log[0]);
    end
    n_tests++;
    if (done_cnt != d0 || rom_words !== 34) begin
      n_fail++; $display("FAIL rs_final: pulses=%0d words=%0d, expected 0 34", done_cnt - d0, rom_words);
    end
  endtask

  task automatic test_random();
    logic [AW+15:0] exp_q[$];
    int exp_words, d0, k;
    logic [AW-1:0] a;
    logic [15:0] d;
    new_download();
    ack_freeze = 1'b0; rnd_ack = 1'b1; req_log.delete();
    d0 = done_cnt; exp_words = 0;
    for (int c = 0; c < 200; c++) begin
      if (ioctl_wait === 1'b0 && $urandom_range(0, 2) != 0) begin
        a = AW'($urandom_range(0, 400) * 2);
        d = 16'($urandom);
        exp_q.push_back({a, sw(d)});
        if (int'(a / 2) + 1 > exp_words) exp_words = int'(a / 2) + 1;
        ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 800) begin tick(); k++; end
    tick(2);
    rnd_ack = 1'b0;
    n_tests++;
    if (req_log.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rnd_count: requests=%0d expected %0d", req_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < req_log.size(); i++) begin
      n_tests++;
      if (req_log[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rnd_word[%0d]: got %h expected %h", i, req_log[i], exp_q[i]);
      end
    end
    n_tests++;
    if (rom_words !== (AW-1)'(exp_words) || overflow !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL rnd_final: words=%0d ovf=%b pulses=%0d, expected %0d 0 1", rom_words, overflow, done_cnt - d0, exp_words);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wait();
    test_end_of_load();
    test_overflow();
    test_async_reset();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Write-side front end for the ROM image path.
- Sits between the hps_io ioctl download port and the DDR3 ROM store (ddram write port).
- Buffers 16-bit ioctl words in a small FIFO, byte-swaps them, and issues them one at a time over the toggle request/ack write handshake.
- Drives ioctl_wait back-pressure, tracks ROM size, and reports end of load.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- AW, 25, ioctl byte-address width.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download active level.
- ioctl_wr  in  1  one-cycle strobe; word valid on ioctl_addr/ioctl_data.
- ioctl_addr  in  AW  byte address, even.
- ioctl_data  in  16  word, file byte order.
- ioctl_wait  out  1  back-pressure to hps_io.
- wraddr  out  AW  write address to ddram.
- din  out  16  byte-swapped data to ddram.
- we_req  out  1  toggle request.
- we_ack  in  1  toggle ack; request pending while we_req != we_ack.
- rom_words  out  AW-1  highest written word index + 1.
- load_done  out  1  one-cycle pulse when the load is fully committed.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (async, reset_n low): FIFO empty; ioctl_wait=0, we_req=0, wraddr=0, din=0, rom_words=0, load_done=0, overflow=0; download edge detector cleared.
- Download rising edge, detected registered (old_dl=0, ioctl_download=1):
  - flush FIFO; rom_words=0; overflow=0; ioctl_wait=0.
  - we_req is not forced. Any pending toggle completes normally.
  - An ioctl_wr in that same cycle is captured after the flush, so it is kept.
- Capture: ioctl_wr=1 and FIFO not full -> push {ioctl_addr, {ioctl_data[7:0], ioctl_data[15:8]}}.
  - rom_words := max(rom_words, ioctl_addr[AW-1:1]+1).
  - ioctl_wr while full -> word dropped, overflow := 1.
- Issue rule: when we_req == we_ack and FIFO not empty:
  - load head into wraddr/din, toggle we_req, pop. All in one edge.
  - A word captured into an empty FIFO at edge N appears on wraddr/din with we_req toggled at edge N+1.
  - At most one request is outstanding. wraddr/din are held stable until we_ack matches.
- Simultaneous push and pop: count unchanged; FIFO wraps through modulo-DEPTH pointers.
- ioctl_wait is registered: 1 when count after this edge >= DEPTH-1, else 0.
  - This leaves one slot for a write already in flight when wait rises.
  - ioctl_wait is forced to 0 while ioctl_download=0.
- load_done: single-cycle pulse when all of the following hold, with a completion flag armed by a download falling edge:
  - ioctl_download=0
  - FIFO empty
  - we_req == we_ack
  - The flag clears after the pulse.
  - The FIFO keeps draining after the falling edge.
  - A new rising edge before completion cancels the flag; no pulse is emitted.
- ioctl_wr while ioctl_download=0: ignored, no push, no overflow.
- Reset mid-transfer: everything returns to reset values immediately. ddram must be reset on the same reset.

Decomposition:
- Package rom_loader_pkg:
  - localparam ROM_AW=25.
  - typedef rom_entry_t {logic [ROM_AW-1:0] addr; logic [15:0] data;}.
  - Function bswap16.
- One sub-module: sync_fifo (parameterised width/depth).
  - Outputs: count, full, empty.
  - Behaviour: show-ahead head, async active-low reset, synchronous flush input.
- Top level holds the issue FSM: states IDLE (we_req==we_ack) / BUSY (pending). Also the download edge detect, wait and done logic.

Test Plan:
- Single word, ack after 3 cycles:
  - Stimulus: download rises; write addr=0x000, data=0x1234; ack after 3 cycles.
  - Response: wraddr=0x000, din=0x3412 one cycle after capture; we_req toggles once; no further toggle until we_ack matches.
- Ack withheld, DEPTH=4:
  - Stimulus: 5 back-to-back writes at addr 0x0,0x2,...,0x8; ack held for 20 cycles.
  - Response: ioctl_wait=1 after the 3rd word is buffered (one issued, three queued); no overflow.
  - After acks resume: five requests issued in address order; rom_words=5.
- End of load:
  - Stimulus: download falls with 2 words still queued; each ack takes 2 cycles.
  - Response: load_done pulses exactly once, the cycle after the final we_ack match; rom_words unchanged.
- Overflow:
  - Stimulus: ignore ioctl_wait and issue 6 writes while ack is frozen.
  - Response: overflow=1; the 6th word is never issued.
  - Next download rising edge clears overflow.
- Async reset mid-transfer:
  - Stimulus: reset_n pulsed low mid-transfer with 2 words queued.
  - Response: all outputs at reset values immediately; no load_done; first new write after reset issues normally.
- Restart before drain:
  - Stimulus: download restarts before the previous drain completes.
  - Response: no load_done; FIFO flushed; the outstanding request still completes; new words follow.
